// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// One access every two cycles; round-robin or fixed priority between ports.
//
// state  | meaning
// IDLE   | waiting for a request; picks a winner and latches its command
// ACCESS | memory driven with the latched command; read data captured at end
module data_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_signal_write,
    output logic [ADDR_W-1:0] mem_addr_rw,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic                last;
    logic                cmd_we;
    logic                cmd_port;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                pick;

    // pick = 1 selects port 1
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last;
        end else begin
            pick = req1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_port  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == IDLE) begin
                if (req0 || req1) begin
                    state     <= ACCESS;
                    busy      <= 1'b1;
                    last      <= pick;
                    cmd_port  <= pick;
                    cmd_we    <= pick ? we1 : we0;
                    cmd_addr  <= pick ? addr1 : addr0;
                    cmd_wdata <= pick ? wdata1 : wdata0;
                    gnt0      <= ~pick;
                    gnt1      <= pick;
                end
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
                gnt0  <= 1'b0;
                gnt1  <= 1'b0;
                if (!cmd_we) begin
                    if (cmd_port) begin
                        rdata1  <= mem_data_read;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= mem_data_read;
                        rvalid0 <= 1'b1;
                    end
                end
            end
        end
    end

    // reset gates the strobe directly so an in-flight write is squashed
    assign mem_signal_write = (state == ACCESS) && cmd_we && !reset;
    assign mem_addr_rw      = cmd_addr;
    assign mem_data_write   = cmd_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus,
// each with its own 256x16 memory model.
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;

    logic        rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_busy, rr_we;
    logic [15:0] rr_rdata0, rr_rdata1, rr_wdata, rr_rd;
    logic [7:0]  rr_addr;
    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_busy, fp_we;
    logic [15:0] fp_rdata0, fp_rdata1, fp_wdata, fp_rd;
    logic [7:0]  fp_addr;

    logic [15:0] rr_mem [256] = '{default: 16'h0000};
    logic [15:0] fp_mem [256] = '{default: 16'h0000};

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) if (rr_we) rr_mem[rr_addr] <= rr_wdata;
    always @(posedge clock) if (fp_we) fp_mem[fp_addr] <= fp_wdata;
    assign rr_rd = rr_mem[rr_addr];
    assign fp_rd = fp_mem[fp_addr];

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .rvalid0(rr_rvalid0), .rvalid1(rr_rvalid1),
        .rdata0(rr_rdata0), .rdata1(rr_rdata1), .busy(rr_busy),
        .mem_signal_write(rr_we), .mem_addr_rw(rr_addr),
        .mem_data_write(rr_wdata), .mem_data_read(rr_rd)
    );

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
        .rdata0(fp_rdata0), .rdata1(fp_rdata1), .busy(fp_busy),
        .mem_signal_write(fp_we), .mem_addr_rw(fp_addr),
        .mem_data_write(fp_wdata), .mem_data_read(fp_rd)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_busy, rr_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_busy, rr_we});
        end
        tests++;
        if ({rr_rdata0, rr_rdata1, rr_addr, rr_wdata} !== 56'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {rr_rdata0, rr_rdata1, rr_addr, rr_wdata});
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hBEEF;
        tick();
        tests++;
        if ({rr_gnt0, rr_gnt1, rr_busy, rr_we} !== 4'b1011 || rr_addr !== 8'h10 || rr_wdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL wr_access got gnt0=%b gnt1=%b busy=%b we=%b addr=%h data=%h want 1 0 1 1 10 beef",
                     rr_gnt0, rr_gnt1, rr_busy, rr_we, rr_addr, rr_wdata);
        end
        req0 = 1'b0;
        tick();
        tests++;
        if ({rr_gnt0, rr_busy, rr_we, rr_rvalid0} !== 4'b0000 || rr_mem[8'h10] !== 16'hBEEF) begin
            fails++;
            $display("FAIL wr_done got gnt0=%b busy=%b we=%b rvalid0=%b mem=%h want 0 0 0 0 beef",
                     rr_gnt0, rr_busy, rr_we, rr_rvalid0, rr_mem[8'h10]);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        tick();
        tests++;
        if ({rr_gnt0, rr_we, rr_rvalid0} !== 3'b100) begin
            fails++;
            $display("FAIL rd_access got gnt0=%b we=%b rvalid0=%b want 1 0 0", rr_gnt0, rr_we, rr_rvalid0);
        end
        req0 = 1'b0;
        tick();
        tests++;
        if (rr_rvalid0 !== 1'b1 || rr_rdata0 !== 16'hBEEF || rr_gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL rd_data got rvalid0=%b rdata0=%h gnt0=%b want 1 beef 0", rr_rvalid0, rr_rdata0, rr_gnt0);
        end
        tick();
        tests++;
        if (rr_rvalid0 !== 1'b0 || rr_rdata0 !== 16'hBEEF) begin
            fails++;
            $display("FAIL rd_hold got rvalid0=%b rdata0=%h want 0 beef", rr_rvalid0, rr_rdata0);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] rr_exp;
        do_reset();
        rr_exp = 4'b1010;  // 1 = port 0 granted, in grant order from bit 3
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h11;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (rr_gnt0 !== rr_exp[3-i] || rr_gnt1 !== ~rr_exp[3-i]) begin
                fails++;
                $display("FAIL rr_grant%0d got gnt0=%b gnt1=%b want %b %b", i, rr_gnt0, rr_gnt1,
                         rr_exp[3-i], ~rr_exp[3-i]);
            end
            tests++;
            if (fp_gnt0 !== 1'b1 || fp_gnt1 !== 1'b0) begin
                fails++;
                $display("FAIL fp_grant%0d got gnt0=%b gnt1=%b want 1 0", i, fp_gnt0, fp_gnt1);
            end
            tick();
            tests++;
            if (rr_gnt0 !== 1'b0 || rr_gnt1 !== 1'b0 || rr_rvalid0 !== rr_exp[3-i] || rr_rvalid1 !== ~rr_exp[3-i]) begin
                fails++;
                $display("FAIL rr_idle%0d got gnt=%b%b rvalid=%b%b", i, rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1);
            end
        end
        req0 = 1'b0;
        tick();
        tests++;
        if (fp_gnt1 !== 1'b1 || fp_gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL fp_starve_release got gnt0=%b gnt1=%b want 0 1", fp_gnt0, fp_gnt1);
        end
        req1 = 1'b0;
        tick();
        tests++;
        if (fp_rvalid1 !== 1'b1 || fp_rdata1 !== fp_mem[8'h11]) begin
            fails++;
            $display("FAIL fp_rvalid1 got rvalid1=%b rdata1=%h want 1 %h", fp_rvalid1, fp_rdata1, fp_mem[8'h11]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        tick();
        req0 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'hFF;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 16'h1234;
        tick();
        tests++;
        if (rr_gnt1 !== 1'b1 || rr_gnt0 !== 1'b0 || rr_we !== 1'b1) begin
            fails++;
            $display("FAIL coll_first got gnt0=%b gnt1=%b we=%b want 0 1 1", rr_gnt0, rr_gnt1, rr_we);
        end
        req1 = 1'b0;
        tick();
        tests++;
        if (rr_rvalid1 !== 1'b0 || rr_mem[8'hFF] !== 16'h1234) begin
            fails++;
            $display("FAIL coll_write got rvalid1=%b mem=%h want 0 1234", rr_rvalid1, rr_mem[8'hFF]);
        end
        tick();
        tests++;
        if (rr_gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL coll_second got gnt0=%b want 1", rr_gnt0);
        end
        req0 = 1'b0;
        tick();
        tests++;
        if (rr_rvalid0 !== 1'b1 || rr_rdata0 !== 16'h1234 || rr_rvalid1 !== 1'b0) begin
            fails++;
            $display("FAIL coll_read got rvalid0=%b rdata0=%h rvalid1=%b want 1 1234 0",
                     rr_rvalid0, rr_rdata0, rr_rvalid1);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'hAAAA;
        tick();
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if (rr_we !== 1'b0 || rr_gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL squash_we got we=%b gnt0=%b want 0 1", rr_we, rr_gnt0);
        end
        tick();
        reset = 1'b0;
        tests++;
        if ({rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_busy, rr_we} !== 6'b0 || rr_addr !== 8'h00 ||
            rr_mem[8'h20] !== 16'h0000) begin
            fails++;
            $display("FAIL squash_after got ctrl=%b addr=%h mem=%h want 000000 00 0000",
                     {rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_busy, rr_we}, rr_addr, rr_mem[8'h20]);
        end
        rr_mem[8'hFF] = 16'h5555;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'hFF;
        tick();
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        tick();
        req0 = 1'b0;
        tick();
        tests++;
        if (rr_rvalid0 !== 1'b1 || rr_rdata0 !== 16'h0000) begin
            fails++;
            $display("FAIL squash_read got rvalid0=%b rdata0=%h want 1 0000", rr_rvalid0, rr_rdata0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] busy_exp;
        busy_exp = 4'b1010;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (rr_busy !== busy_exp[3-i] || rr_gnt0 !== busy_exp[3-i] || rr_rvalid0 !== ~busy_exp[3-i]) begin
                fails++;
                $display("FAIL b2b_step%0d got busy=%b gnt0=%b rvalid0=%b want %b %b %b", i, rr_busy,
                         rr_gnt0, rr_rvalid0, busy_exp[3-i], busy_exp[3-i], ~busy_exp[3-i]);
            end
        end
        req0 = 1'b0;
        tests++;
        if (rr_rdata0 !== 16'hBEEF) begin
            fails++;
            $display("FAIL b2b_data got %h want beef", rr_rdata0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_collision();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
